// File: rtl/golomb_rice_decode_pkg.sv
// Shared types and constants for the Golomb-Rice codeword parser.
package golomb_rice_pkg;

    localparam int K_W    = 3;
    localparam int BUF_W  = 64;
    localparam int WORD_W = 32;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int PEEK_W = 8;
    localparam int POP_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNARY,
        ST_REM,
        ST_SIGN,
        ST_OUT
    } grd_state_t;

    // Right-justify the top n bits of the peek window (n in 1..7).
    function automatic logic [PEEK_W-1:0] take_bits(input logic [PEEK_W-1:0] peek,
                                                    input logic [K_W-1:0]    n);
        return peek >> (PEEK_W - int'(n));
    endfunction

endpackage

// File: rtl/golomb_rice_decode_bit_buffer.sv
// MSB-aligned 64-bit bit buffer: pushes 32-bit words behind the valid bits,
// pops 0..8 bits from the front each cycle.
module grd_bit_buffer
    import golomb_rice_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] push_data,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [POP_W-1:0]  pop_n,
    output logic [PEEK_W-1:0] peek,
    output logic [FILL_W-1:0] fill
);

    logic [BUF_W-1:0]  bits;
    logic [BUF_W-1:0]  kept;
    logic [FILL_W-1:0] fill_kept;
    logic              push_fire;

    assign push_ready = (fill <= FILL_W'(WORD_W));
    assign push_fire  = push_valid && push_ready;
    assign peek       = bits[BUF_W-1 -: PEEK_W];

    // Bits below the fill point are always zero, so a new word can be OR-ed in.
    always_comb begin
        kept      = bits << pop_n;
        fill_kept = fill - FILL_W'(pop_n);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bits <= '0;
            fill <= '0;
        end else if (push_fire) begin
            bits <= kept | ({push_data, {WORD_W{1'b0}}} >> fill_kept);
            fill <= fill_kept + FILL_W'(WORD_W);
        end else begin
            bits <= kept;
            fill <= fill_kept;
        end
    end

endmodule

// File: rtl/golomb_rice_decode.sv
// Golomb-Rice codeword parser: one codeword per command from an MSB-first word stream.
// Optional prefix-overflow detection is enabled by defining GOLOMB_RICE_DECODE_ERR_EN.
module golomb_rice_decode
    import golomb_rice_pkg::*;
#(
    parameter int MAX_Q = 31,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K_W-1:0]    cmd_k,
    input  logic              cmd_is_ac,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [OUT_W-1:0]  val,
    output logic              is_minus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    localparam int Q_W = $clog2(MAX_Q + 1) + 1;

    grd_state_t        state, state_nx;
    logic [K_W-1:0]    k_r;
    logic              ac_r;
    logic [Q_W-1:0]    q_r, q_nx;
    logic [PEEK_W-1:0] rem_r, rem_nx;
    logic              sign_r, sign_nx;
    logic [OUT_W-1:0]  val_nx;
    logic              load_out;
    logic [POP_W-1:0]  pop_n;
    logic [PEEK_W-1:0] peek;
    logic [FILL_W-1:0] fill;
    logic              have_bit;
    logic              have_rem;
`ifdef GOLOMB_RICE_DECODE_ERR_EN
    logic              err_nx;
`endif

    grd_bit_buffer u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_data  (in_data),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .pop_n      (pop_n),
        .peek       (peek),
        .fill       (fill)
    );

    assign have_bit  = (fill != '0);
    assign have_rem  = (fill >= FILL_W'(k_r));
    // Held low while reset is asserted so no command is taken during reset.
    assign cmd_ready = reset_n && (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);

    always_comb begin
        state_nx = state;
        q_nx     = q_r;
        rem_nx   = rem_r;
        sign_nx  = sign_r;
        pop_n    = '0;
`ifdef GOLOMB_RICE_DECODE_ERR_EN
        err_nx   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    q_nx     = '0;
                    rem_nx   = '0;
                    sign_nx  = 1'b0;
                    state_nx = ST_UNARY;
                end
            end
            ST_UNARY: begin
                if (have_bit) begin
                    pop_n = POP_W'(1);
                    if (peek[PEEK_W-1]) begin
                        if (k_r != '0)
                            state_nx = ST_REM;
                        else if (ac_r)
                            state_nx = ST_SIGN;
                        else
                            state_nx = ST_OUT;
                    end else begin
`ifdef GOLOMB_RICE_DECODE_ERR_EN
                        if (q_r == Q_W'(MAX_Q)) begin
                            err_nx   = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
                            q_nx = q_r + Q_W'(1);
                        end
`else
                        q_nx = q_r + Q_W'(1);
`endif
                    end
                end
            end
            ST_REM: begin
                if (have_rem) begin
                    pop_n    = POP_W'(k_r);
                    rem_nx   = take_bits(peek, k_r);
                    state_nx = ac_r ? ST_SIGN : ST_OUT;
                end
            end
            ST_SIGN: begin
                if (have_bit) begin
                    pop_n    = POP_W'(1);
                    sign_nx  = peek[PEEK_W-1];
                    state_nx = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        load_out = (state_nx == ST_OUT) && (state != ST_OUT);
        val_nx   = (OUT_W'(q_nx) << k_r) | OUT_W'(rem_nx);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            k_r      <= '0;
            ac_r     <= 1'b0;
            q_r      <= '0;
            rem_r    <= '0;
            sign_r   <= 1'b0;
            val      <= '0;
            is_minus <= 1'b0;
        end else begin
            state  <= state_nx;
            q_r    <= q_nx;
            rem_r  <= rem_nx;
            sign_r <= sign_nx;
            if (cmd_valid && cmd_ready) begin
                k_r  <= cmd_k;
                ac_r <= cmd_is_ac;
            end
            if (load_out) begin
                val      <= val_nx;
                is_minus <= ac_r & sign_nx;
            end
        end
    end

`ifdef GOLOMB_RICE_DECODE_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            err <= 1'b0;
        else
            err <= err_nx;
    end
`else
    assign err = 1'b0;
`endif

endmodule
